// File: rtl/entity_frame_buffer.sv
// Double-buffered entity table for the PPU: game logic fills a shadow bank,
// which is copied to the active bank at the start of vertical blanking after a commit.
module entity_frame_buffer #(
  parameter logic [3:0] EMPTY_ID = 4'hF,
  parameter int         MISS_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_slot,
  input  logic [17:0]       wr_data,
  input  logic              clear_shadow,
  input  logic              commit,
  input  logic              frame_start,
  output logic [13:0]       entity_1,
  output logic [13:0]       entity_2,
  output logic [13:0]       entity_3,
  output logic [13:0]       entity_4,
  output logic [13:0]       entity_5,
  output logic [13:0]       entity_6,
  output logic [17:0]       entity_7,
  output logic [13:0]       entity_8_flip,
  output logic [13:0]       entity_9_flip,
  output logic              swapped,
  output logic              bad_slot,
  output logic [MISS_W-1:0] missed_frames
);

  localparam logic [13:0] EMPTY14 = {EMPTY_ID, 10'b0};

  typedef enum logic [1:0] {FILL, PENDING, SWAP} state_t;

  state_t state_q;
  // Slot 6 is 18 bits wide; its upper nibble lives in the separate _ext registers.
  logic [13:0] sh_q [9];
  logic [13:0] sh_d [9];
  logic [13:0] act_q [9];
  logic [3:0]  sh_ext_q, sh_ext_d, act_ext_q;
  logic        swapped_q, bad_q;
  logic [MISS_W-1:0] miss_q;
  logic        wr_fire;

  assign wr_ready = (state_q == FILL);
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    sh_d     = sh_q;
    sh_ext_d = sh_ext_q;
    if (state_q == FILL && clear_shadow) begin
      for (int i = 0; i < 9; i++) sh_d[i] = (i == 6) ? 14'b0 : EMPTY14;
      sh_ext_d = EMPTY_ID;
    end
    // A write in the same cycle as a clear wins for its own slot.
    if (wr_fire) begin
      for (int i = 0; i < 9; i++) begin
        if (wr_slot == 4'(i)) begin
          sh_d[i] = wr_data[13:0];
          if (i == 6) sh_ext_d = wr_data[17:14];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      for (int i = 0; i < 9; i++) begin
        sh_q[i]  <= (i == 6) ? 14'b0 : EMPTY14;
        act_q[i] <= (i == 6) ? 14'b0 : EMPTY14;
      end
      sh_ext_q  <= EMPTY_ID;
      act_ext_q <= EMPTY_ID;
      swapped_q <= 1'b0;
      bad_q     <= 1'b0;
      miss_q    <= '0;
    end else begin
      sh_q      <= sh_d;
      sh_ext_q  <= sh_ext_d;
      swapped_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (wr_fire && wr_slot > 4'd8) bad_q <= 1'b1;
          if (commit) begin
            state_q <= PENDING;
          end else if (frame_start && miss_q != '1) begin
            miss_q <= miss_q + MISS_W'(1);
          end
        end
        PENDING: begin
          if (frame_start) begin
            state_q   <= SWAP;
            act_q     <= sh_q;
            act_ext_q <= sh_ext_q;
            swapped_q <= 1'b1;
          end
        end
        SWAP:    state_q <= FILL;
        default: state_q <= FILL;
      endcase
    end
  end

  assign entity_1      = act_q[0];
  assign entity_2      = act_q[1];
  assign entity_3      = act_q[2];
  assign entity_4      = act_q[3];
  assign entity_5      = act_q[4];
  assign entity_6      = act_q[5];
  assign entity_7      = {act_ext_q, act_q[6]};
  assign entity_8_flip = act_q[7];
  assign entity_9_flip = act_q[8];
  assign swapped       = swapped_q;
  assign bad_slot      = bad_q;
  assign missed_frames = miss_q;

endmodule
